// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters (ALU result, memory load) and the
// register-file write port that the arbiter drives.
interface regfile_wb_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_data;

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output mem_valid, mem_rd, mem_data,
    input  mem_ready,
    input  rf_we, rf_rd, rf_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  mem_valid, mem_rd, mem_data,
    output mem_ready,
    output rf_we, rf_rd, rf_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter for the single register-file write port:
// round-robin or fixed ALU priority, $zero suppression, contention counter.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned RR_EN  = 1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  regfile_wb_arbiter_if.slave bus,
  output logic              last_grant,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [0:0]       PRI_ALU = 1'b0;
  localparam logic [0:0]       PRI_MEM = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [0:0]        state_q, state_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic alu_grant_s;
  logic mem_grant_s;
  logic both_valid_s;

  // Grant decision; reset blocks both requesters so nothing is consumed.
  always_comb begin
    alu_grant_s  = 1'b0;
    mem_grant_s  = 1'b0;
    both_valid_s = 1'b0;
    if (rst) begin
      alu_grant_s  = 1'b0;
      mem_grant_s  = 1'b0;
      both_valid_s = 1'b0;
    end else begin
      both_valid_s = bus.alu_valid && bus.mem_valid;
      alu_grant_s  = bus.alu_valid && (!bus.mem_valid || (state_q == PRI_ALU));
      mem_grant_s  = bus.mem_valid && !alu_grant_s;
    end
  end

  // Priority rotation: the winner drops to low priority; idle cycles hold.
  always_comb begin
    state_d = state_q;
    if (RR_EN == 0) begin
      state_d = PRI_ALU;
    end else begin
      case (state_q)
        PRI_ALU: begin
          if (alu_grant_s) begin
            state_d = PRI_MEM;
          end else begin
            state_d = PRI_ALU;
          end
        end
        PRI_MEM: begin
          if (mem_grant_s) begin
            state_d = PRI_ALU;
          end else begin
            state_d = PRI_MEM;
          end
        end
        default: state_d = PRI_ALU;
      endcase
    end
  end

  // Winning request toward the register file; $zero targets are consumed
  // and tracked in rf_rd/rf_data but never raise the write enable.
  always_comb begin
    rf_we_d      = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_data_d    = rf_data_q;
    last_grant_d = last_grant_q;
    if (alu_grant_s) begin
      rf_we_d      = (bus.alu_rd != {ADDR_W{1'b0}});
      rf_rd_d      = bus.alu_rd;
      rf_data_d    = bus.alu_data;
      last_grant_d = 1'b0;
    end else if (mem_grant_s) begin
      rf_we_d      = (bus.mem_rd != {ADDR_W{1'b0}});
      rf_rd_d      = bus.mem_rd;
      rf_data_d    = bus.mem_data;
      last_grant_d = 1'b1;
    end else begin
      rf_we_d      = 1'b0;
      rf_rd_d      = rf_rd_q;
      rf_data_d    = rf_data_q;
      last_grant_d = last_grant_q;
    end
  end

  // Saturating contention counter.
  always_comb begin
    cnt_d = cnt_q;
    if (both_valid_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= PRI_ALU;
      rf_we_q      <= 1'b0;
      rf_rd_q      <= {ADDR_W{1'b0}};
      rf_data_q    <= {DATA_W{1'b0}};
      last_grant_q <= 1'b0;
      cnt_q        <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      rf_we_q      <= rf_we_d;
      rf_rd_q      <= rf_rd_d;
      rf_data_q    <= rf_data_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.alu_ready = alu_grant_s;
  assign bus.mem_ready = mem_grant_s;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_rd     = rf_rd_q;
  assign bus.rf_data   = rf_data_q;
  assign last_grant    = last_grant_q;
  assign conflict_cnt  = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Drives three arbiter configurations (round-robin, fixed priority, 4-bit
// counter) and compares each against a behavioural model of the arbitration rules.
module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Per-configuration stimulus and observed outputs (index = configuration).
  logic [2:0]        av, mv;
  logic [2:0][4:0]   ard, mrd;
  logic [2:0][31:0]  adat, mdat;
  logic [2:0]        ardy, mrdy, we, lg;
  logic [2:0][4:0]   rrd;
  logic [2:0][31:0]  rdat;
  logic [2:0][7:0]   cntv;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned RR = (g == 1) ? 0 : 1;
    localparam int unsigned CW = (g == 2) ? 4 : 8;
    logic [CW-1:0] cnt_w;
    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    assign bus.alu_valid = av[g];
    assign bus.alu_rd    = ard[g];
    assign bus.alu_data  = adat[g];
    assign bus.mem_valid = mv[g];
    assign bus.mem_rd    = mrd[g];
    assign bus.mem_data  = mdat[g];
    assign ardy[g] = bus.alu_ready;
    assign mrdy[g] = bus.mem_ready;
    assign we[g]   = bus.rf_we;
    assign rrd[g]  = bus.rf_rd;
    assign rdat[g] = bus.rf_data;
    assign cntv[g] = 8'(cnt_w);
    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .RR_EN(RR), .CNT_W(CW)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus.slave),
      .last_grant   (lg[g]),
      .conflict_cnt (cnt_w)
    );
  end

  // Reference model state.
  bit          rr_en[3] = '{1'b1, 1'b0, 1'b1};
  int          cmax[3]  = '{255, 255, 15};
  bit          mem_first[3];
  bit          e_we[3];
  logic [4:0]  e_rd[3];
  logic [31:0] e_dat[3];
  bit          e_lg[3];
  int          e_cnt[3];
  bit          ga_last[3], gm_last[3];

  int vectors = 0;
  int errors  = 0;

  task automatic set_req(input int c, input bit a_v, input logic [4:0] a_rd, input logic [31:0] a_d,
                         input bit m_v, input logic [4:0] m_rd, input logic [31:0] m_d);
    av[c] = a_v; ard[c] = a_rd; adat[c] = a_d;
    mv[c] = m_v; mrd[c] = m_rd; mdat[c] = m_d;
  endtask

  // One clock: check readys mid-cycle, advance the model at the edge, check outputs after it.
  task automatic step(input string tag);
    #1;
    for (int c = 0; c < 3; c++) begin
      bit ga, gm;
      ga = 1'b0; gm = 1'b0;
      if (!rst) begin
        if (av[c] && mv[c]) begin
          if (rr_en[c] && mem_first[c]) gm = 1'b1; else ga = 1'b1;
        end else begin
          ga = av[c];
          gm = mv[c];
        end
      end
      ga_last[c] = ga; gm_last[c] = gm;
      vectors++;
      if (ardy[c] !== ga) begin
        errors++; $display("FAIL %s c%0d alu_ready: got %b exp %b", tag, c, ardy[c], ga);
      end
      vectors++;
      if (mrdy[c] !== gm) begin
        errors++; $display("FAIL %s c%0d mem_ready: got %b exp %b", tag, c, mrdy[c], gm);
      end
    end
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      if (rst) begin
        e_we[c] = 1'b0; e_rd[c] = 5'd0; e_dat[c] = 32'd0; e_lg[c] = 1'b0;
        e_cnt[c] = 0; mem_first[c] = 1'b0;
      end else begin
        if (av[c] && mv[c] && e_cnt[c] < cmax[c]) e_cnt[c] = e_cnt[c] + 1;
        if (ga_last[c]) begin
          e_we[c] = (ard[c] != 5'd0); e_rd[c] = ard[c]; e_dat[c] = adat[c]; e_lg[c] = 1'b0;
          if (rr_en[c]) mem_first[c] = 1'b1;
        end else if (gm_last[c]) begin
          e_we[c] = (mrd[c] != 5'd0); e_rd[c] = mrd[c]; e_dat[c] = mdat[c]; e_lg[c] = 1'b1;
          if (rr_en[c]) mem_first[c] = 1'b0;
        end else begin
          e_we[c] = 1'b0;
        end
      end
    end
    #1;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (we[c] !== e_we[c] || rrd[c] !== e_rd[c] || rdat[c] !== e_dat[c]) begin
        errors++;
        $display("FAIL %s c%0d rf write: got we=%b rd=%0d data=%h exp we=%b rd=%0d data=%h",
                 tag, c, we[c], rrd[c], rdat[c], e_we[c], e_rd[c], e_dat[c]);
      end
      vectors++;
      if (lg[c] !== e_lg[c]) begin
        errors++; $display("FAIL %s c%0d last_grant: got %b exp %b", tag, c, lg[c], e_lg[c]);
      end
      vectors++;
      if (cntv[c] !== 8'(e_cnt[c])) begin
        errors++; $display("FAIL %s c%0d conflict_cnt: got %0d exp %0d", tag, c, cntv[c], e_cnt[c]);
      end
    end
    @(negedge clk);
  endtask

  // Requesters that were served present a fresh nonzero-destination request.
  task automatic refresh_both();
    for (int c = 0; c < 3; c++) begin
      if (ga_last[c]) begin ard[c] = 5'($urandom_range(1, 31)); adat[c] = $urandom; end
      if (gm_last[c]) begin mrd[c] = 5'($urandom_range(1, 31)); mdat[c] = $urandom; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step("reset_pulse");
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) set_req(c, 1'b1, 5'd3, 32'h3333_3333, 1'b1, 5'd4, 32'h4444_4444);
    step("reset");
    vectors++;
    if (we[0] !== 1'b0 || cntv[0] !== 8'd0 || lg[0] !== 1'b0) begin
      errors++; $display("FAIL reset_state: got we=%b cnt=%0d lg=%b exp 0/0/0", we[0], cntv[0], lg[0]);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu_only();
    for (int c = 0; c < 3; c++) set_req(c, 1'b1, 5'd5, 32'h1002_AAFF, 1'b0, 5'd0, 32'd0);
    step("alu_only");
    vectors++;
    if (we[0] !== 1'b1 || rrd[0] !== 5'd5 || rdat[0] !== 32'h1002_AAFF) begin
      errors++; $display("FAIL alu_only_write: got we=%b rd=%0d data=%h exp 1/5/1002aaff", we[0], rrd[0], rdat[0]);
    end
    for (int c = 0; c < 3; c++) av[c] = 1'b0;
    step("alu_only_idle");
    vectors++;
    if (we[0] !== 1'b0 || rrd[0] !== 5'd5) begin
      errors++; $display("FAIL alu_only_after: got we=%b rd=%0d exp 0/5", we[0], rrd[0]);
    end
  endtask

  task automatic test_contention();
    logic [3:0] exp_lg;
    exp_lg = 4'b1010;
    do_reset();
    for (int c = 0; c < 3; c++) set_req(c, 1'b1, 5'd7, $urandom, 1'b1, 5'd9, $urandom);
    for (int k = 0; k < 4; k++) begin
      step("contention");
      vectors++;
      if (lg[0] !== exp_lg[k] || we[0] !== 1'b1) begin
        errors++; $display("FAIL rr_order k=%0d: got lg=%b we=%b exp lg=%b we=1", k, lg[0], we[0], exp_lg[k]);
      end
      vectors++;
      if (mrdy[1] !== 1'b0 || lg[1] !== 1'b0) begin
        errors++; $display("FAIL fixed_starve k=%0d: got mem_ready=%b lg=%b exp 0/0", k, mrdy[1], lg[1]);
      end
      refresh_both();
    end
    vectors++;
    if (cntv[0] !== 8'd4 || cntv[1] !== 8'd4) begin
      errors++; $display("FAIL contention_cnt: got %0d/%0d exp 4/4", cntv[0], cntv[1]);
    end
  endtask

  task automatic test_zero_write();
    do_reset();
    for (int c = 0; c < 3; c++) set_req(c, 1'b1, 5'd2, 32'h0000_0002, 1'b0, 5'd0, 32'd0);
    step("zero_pre");
    for (int c = 0; c < 3; c++) set_req(c, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    step("zero_write");
    vectors++;
    if (we[0] !== 1'b0 || rdat[0] !== 32'hDEAD_BEEF || lg[0] !== 1'b1) begin
      errors++; $display("FAIL zero_write: got we=%b data=%h lg=%b exp 0/deadbeef/1", we[0], rdat[0], lg[0]);
    end
    for (int c = 0; c < 3; c++) set_req(c, 1'b1, 5'd6, 32'h0000_0006, 1'b1, 5'd8, 32'h0000_0008);
    step("zero_rotate");
    vectors++;
    if (lg[0] !== 1'b0 || rrd[0] !== 5'd6) begin
      errors++; $display("FAIL zero_rotate: got lg=%b rd=%0d exp 0/6", lg[0], rrd[0]);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c < 3; c++) set_req(c, 1'b1, 5'd1, $urandom, 1'b1, 5'd2, $urandom);
    for (int k = 0; k < 20; k++) begin
      step("saturate");
      refresh_both();
    end
    vectors++;
    if (cntv[2] !== 8'd15 || cntv[0] !== 8'd20) begin
      errors++; $display("FAIL saturation: got %0d/%0d exp 15/20", cntv[2], cntv[0]);
    end
  endtask

  task automatic test_mid_reset();
    for (int c = 0; c < 3; c++) set_req(c, 1'b1, 5'd12, 32'hCAFE_0012, 1'b1, 5'd13, 32'hCAFE_0013);
    step("mid_accept");
    rst = 1'b1;
    step("mid_reset");
    vectors++;
    if (we[0] !== 1'b0 || cntv[0] !== 8'd0 || lg[0] !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got we=%b cnt=%0d lg=%b exp 0/0/0", we[0], cntv[0], lg[0]);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3; c++) set_req(c, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int c = 0; c < 3; c++) begin
        if (!av[c] || ga_last[c]) begin
          av[c] = ($urandom_range(0, 2) != 0);
          ard[c] = 5'($urandom_range(0, 31));
          adat[c] = $urandom;
        end
        if (!mv[c] || gm_last[c]) begin
          mv[c] = ($urandom_range(0, 2) != 0);
          mrd[c] = 5'($urandom_range(0, 31));
          mdat[c] = $urandom;
        end
      end
      step("random");
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < 3; c++) set_req(c, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    test_reset();
    test_alu_only();
    test_contention();
    test_zero_write();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (we, rd, dataIn) between two writeback requesters: the ALU result path and the memory load path.
- Arbitrates with round-robin priority (or fixed ALU priority), suppresses writes to $zero and registers the winning write toward the register file.
- Counts contention cycles for performance debug.

Parameters:
DATA_W, 32, width of writeback data
ADDR_W, 5, register address width
RR_EN, 1, 1 = round-robin priority, 0 = fixed ALU-over-MEM priority
CNT_W, 8, width of saturating contention counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
alu_valid  input  1  ALU writeback request
alu_rd  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
alu_ready  output  1  ALU request accepted this cycle (combinational)
mem_valid  input  1  load writeback request
mem_rd  input  ADDR_W  load destination register
mem_data  input  DATA_W  load data
mem_ready  output  1  load request accepted this cycle (combinational)
rf_we  output  1  register-file write enable (registered)
rf_rd  output  ADDR_W  register-file write address (registered)
rf_data  output  DATA_W  register-file write data (registered)
last_grant  output  1  0 = ALU, 1 = MEM won the most recent grant
conflict_cnt  output  CNT_W  saturating count of cycles with both requests valid

Behaviour:
- Reset (rst=1 at a clk edge): rf_we=0, rf_rd=0, rf_data=0, conflict_cnt=0, state=PRI_ALU, last_grant=0. While rst=1, alu_ready=mem_ready=0.
- Handshake: transfer occurs when valid && ready in the same cycle. A requester holds valid, rd and data stable until it sees ready. The arbiter never asserts both readys in one cycle.
- Priority FSM, two states:
  - PRI_ALU: ALU wins if both valid.
  - PRI_MEM: MEM wins if both valid.
  - A single valid requester always wins, in either state.
- Transitions with RR_EN=1:
  - Grant to ALU -> PRI_MEM.
  - Grant to MEM -> PRI_ALU.
  - No grant -> hold state.
- RR_EN=0: state is fixed at PRI_ALU; the MEM path is starved while alu_valid is held.
- Grant: alu_ready = !rst && alu_valid && (!mem_valid || state==PRI_ALU). mem_ready = !rst && mem_valid && !alu_ready.
- Write latency is 1 cycle. At the edge after a transfer:
  - rf_we = (granted rd != 0).
  - rf_rd and rf_data take the granted request's values.
  - last_grant updates.
- Cycles without a transfer: rf_we=0; rf_rd and rf_data hold their previous values.
- $zero writes: a request with rd=0 is accepted (ready=1) and consumed. rf_we stays 0, rf_rd and rf_data still update, and the FSM still rotates.
- Same destination from both requesters: no special merging. Each is written in grant order, so the later grant's data persists.
- Back-to-back grants: one write per cycle, no bubbles.
- conflict_cnt increments by 1 every non-reset cycle with alu_valid && mem_valid. It saturates at 2^CNT_W-1 and does not wrap.
- Reset mid-operation: any pending request is not accepted, and the registered write is cancelled (rf_we=0 on the next edge). The FSM returns to PRI_ALU.
- No internal buffering. A requester that is refused retries by holding valid.

Test Plan:
- Reset with both valid (alu_rd=3, mem_rd=4) -> alu_ready=mem_ready=0; the next edge gives rf_we=0, conflict_cnt=0, last_grant=0.
- ALU only: alu_rd=5, alu_data=0x1002AAFF for 1 cycle -> alu_ready=1 that cycle; the next cycle rf_we=1, rf_rd=5, rf_data=0x1002AAFF; then rf_we=0.
- Both valid continuously for 4 cycles, RR_EN=1:
  - Grants go ALU, MEM, ALU, MEM (last_grant 0, 1, 0, 1).
  - conflict_cnt=4.
  - rf_we=1 for 4 consecutive cycles.
- Same stimulus with RR_EN=0 -> ALU wins all 4 cycles and mem_ready stays 0.
- $zero write: mem_rd=0, mem_data=0xDEADBEEF -> mem_ready=1, rf_we stays 0, state flips to PRI_ALU.
- Counter saturation with CNT_W=4: 20 contention cycles -> conflict_cnt=15.
- Mid-operation reset: rst=1 in the cycle after an accepted write is asserted -> rf_we=0 and conflict_cnt=0 at the following edge.
